// File: rtl/shared_arith_sequencer.sv
// Multi-cycle compare/arith sequencer: one WIDTH+1-bit adder/subtractor is time-shared
// between the A<B / A==B compare step and the +/-ADD_K step, scheduled by a 4-state FSM.
module shared_arith_sequencer #(
    parameter int WIDTH = 17,
    parameter int ADD_K = 2,
    parameter int SHIFT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT1,
    output logic [WIDTH-1:0] OUT2,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [7:0]       DONE_CNT
);

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_OP, S_DONE} state_t;

    localparam logic [WIDTH:0] K_EXT = (WIDTH + 1)'(ADD_K);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_lt;
    logic             r_eq;
    logic [WIDTH-1:0] r_out1;
    logic [WIDTH-1:0] r_out2;
    logic             r_out_valid;
    logic [7:0]       r_done_cnt;

    logic [WIDTH:0]   w_rhs;
    logic [WIDTH:0]   w_rhs_sel;
    logic             w_sub;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_shifted;

    // Operand mux for the single adder: CMP subtracts B, OP adds or subtracts ADD_K.
    always_comb begin
        w_sub = 1'b1;
        w_rhs = {1'b0, r_b};
        if (r_state == S_OP) begin
            w_rhs = K_EXT;
            w_sub = !r_lt;
        end
    end

    assign w_rhs_sel = w_sub ? ~w_rhs : w_rhs;
    assign w_sum     = {1'b0, r_a} + w_rhs_sel + {{WIDTH{1'b0}}, w_sub};
    assign w_shifted = r_eq ? (r_b << SHIFT) : (r_b >> SHIFT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_out1      <= '0;
            r_out2      <= '0;
            r_out_valid <= 1'b0;
            r_done_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        r_a     <= IN1;
                        r_b     <= IN2;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    // Zero-extended A-B goes negative (top bit set) exactly when A<B.
                    r_lt    <= w_sum[WIDTH];
                    r_eq    <= (w_sum == '0);
                    r_state <= S_OP;
                end
                S_OP: begin
                    r_out1      <= w_sum[WIDTH-1:0];
                    r_out2      <= w_shifted;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (r_out_valid && OUT_READY) begin
                        r_out_valid <= 1'b0;
                        r_done_cnt  <= r_done_cnt + 8'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign IN_READY  = (r_state == S_IDLE);
    assign OUT1      = r_out1;
    assign OUT2      = r_out2;
    assign OUT_VALID = r_out_valid;
    assign DONE_CNT  = r_done_cnt;

endmodule
